// File: rtl/bus_pkg.sv
// Shared types and helpers for the serial-bus arbiter slice.
package bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StBusy,
    StRelease
  } arb_state_t;

  // Index width for n items; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or after ptr_i, wrapping.
module rr_picker
  import bus_pkg::*;
#(
  parameter int unsigned MASTERS = 2,
  parameter int unsigned IdxW    = id_width(MASTERS)
) (
  input  logic [MASTERS-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic               found_o,
  output logic [MASTERS-1:0] grant_oh_o,
  output logic [IdxW-1:0]    grant_idx_o
);

  int unsigned cand;

  always_comb begin
    found_o     = 1'b0;
    grant_idx_o = '0;
    grant_oh_o  = '0;
    cand        = 0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      cand = (32'(ptr_i) + i) % MASTERS;
      if (!found_o && req_i[cand]) begin
        found_o     = 1'b1;
        grant_idx_o = IdxW'(cand);
      end
    end
    if (found_o) grant_oh_o[grant_idx_o] = 1'b1;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter/router sharing the serial slave bus among several masters.
// Define ARB_TIMEOUT_EN to force release of an owner that stays silent for TIMEOUT BUSY cycles.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned MASTERS = 2,
  parameter int unsigned SLAVES  = 3,
  parameter int unsigned SLAVEID = id_width(SLAVES),
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [MASTERS-1:0]         m_req,
  input  logic [MASTERS*SLAVEID-1:0] m_slave_id,
  input  logic [MASTERS-1:0]         m_done,
  input  logic [MASTERS-1:0]         m_control,
  input  logic [MASTERS-1:0]         m_wD,
  input  logic [MASTERS-1:0]         m_valid,
  input  logic [MASTERS-1:0]         m_last,
  output logic [MASTERS-1:0]         m_grant,
  output logic [MASTERS-1:0]         m_rD,
  output logic [MASTERS-1:0]         m_ready,
  output logic [SLAVES-1:0]          s_control,
  output logic [SLAVES-1:0]          s_wD,
  output logic [SLAVES-1:0]          s_valid,
  output logic [SLAVES-1:0]          s_last,
  input  logic [SLAVES-1:0]          s_rD,
  input  logic [SLAVES-1:0]          s_ready,
  output logic                       busy,
  output logic                       timeout
);

  localparam int unsigned IdxW = id_width(MASTERS);

  if (MASTERS < 2 || TIMEOUT == 0) begin : g_param_check
    $error("bus_arbiter needs MASTERS >= 2 and TIMEOUT >= 1");
  end

  arb_state_t           state_q;
  logic [IdxW-1:0]      owner_q, ptr_q;
  logic [SLAVEID-1:0]   slave_q;
  logic [MASTERS-1:0]   grant_q;
  logic                 busy_q, timeout_q;
  logic                 pick_found, tmo_hit, route_en;
  logic [MASTERS-1:0]   pick_oh;
  logic [IdxW-1:0]      pick_idx;

  rr_picker #(
    .MASTERS (MASTERS),
    .IdxW    (IdxW)
  ) u_rr_picker (
    .req_i       (m_req),
    .ptr_i       (ptr_q),
    .found_o     (pick_found),
    .grant_oh_o  (pick_oh),
    .grant_idx_o (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] idle_cnt_q;
  logic            owner_quiet;

  assign owner_quiet = ~m_valid[owner_q] & ~m_control[owner_q];
  // Fires on the TIMEOUT-th consecutive silent BUSY cycle.
  assign tmo_hit = (state_q == StBusy) && owner_quiet && (idle_cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_cnt_q <= '0;
    end else if (state_q != StBusy || !owner_quiet) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      slave_q   <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_found) begin
            owner_q <= pick_idx;
            slave_q <= m_slave_id[pick_idx*SLAVEID +: SLAVEID];
            grant_q <= pick_oh;
            busy_q  <= 1'b1;
            state_q <= StGrant;
          end
        end
        StGrant: state_q <= StBusy;
        StBusy: begin
          if (m_done[owner_q] || !m_req[owner_q] || tmo_hit) begin
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= tmo_hit;
            state_q   <= StRelease;
          end
        end
        StRelease: begin
          timeout_q <= 1'b0;
          ptr_q     <= (owner_q == IdxW'(MASTERS - 1)) ? '0 : owner_q + 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_grant = grant_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

  // Out-of-range slave IDs keep the grant but route nothing.
  assign route_en = (state_q == StBusy) && (32'(slave_q) < SLAVES);

  always_comb begin
    s_control = '0;
    s_wD      = '0;
    s_valid   = '0;
    s_last    = '0;
    m_rD      = '0;
    m_ready   = '0;
    if (route_en) begin
      s_control[slave_q] = m_control[owner_q];
      s_wD[slave_q]      = m_wD[owner_q];
      s_valid[slave_q]   = m_valid[owner_q];
      s_last[slave_q]    = m_last[owner_q];
      m_rD[owner_q]      = s_rD[slave_q];
      m_ready[owner_q]   = s_ready[slave_q];
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] m_req, m_done, m_control, m_wD, m_valid, m_last;
  logic [3:0] m_slave_id;
  logic [1:0] m_grant, m_rD, m_ready;
  logic [2:0] s_control, s_wD, s_valid, s_last, s_rD, s_ready;
  logic       busy, timeout;

  int checks = 0;
  int failures = 0;

  bus_arbiter #(
    .MASTERS (2),
    .SLAVES  (3),
    .SLAVEID (2),
    .TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m_req      (m_req),
    .m_slave_id (m_slave_id),
    .m_done     (m_done),
    .m_control  (m_control),
    .m_wD       (m_wD),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_grant    (m_grant),
    .m_rD       (m_rD),
    .m_ready    (m_ready),
    .s_control  (s_control),
    .s_wD       (s_wD),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_rD       (s_rD),
    .s_ready    (s_ready),
    .busy       (busy),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [3:0] sid;
    logic [1:0] done, ctl, wd, val, lst;
    logic [2:0] srd, srdy;
    logic [1:0] grant;
    logic [2:0] sctl, swd, sval, slst;
    logic [1:0] mrd, mrdy;
    logic       bsy;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    m_req = '0; m_done = '0; m_control = '0; m_wD = '0; m_valid = '0; m_last = '0;
    m_slave_id = '0; s_rD = '0; s_ready = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    #1;
    chk("rst_grant", 32'(m_grant), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ready", 32'(m_ready), 32'(0));
    chk("rst_timeout", 32'(timeout), 32'(0));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Bounded wait for any grant; counts grant-low cycles seen first.
  task automatic wait_grant(output int lows);
    lows = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      m_done = '0;
      #1;
      if (m_grant != '0) return;
      lows++;
    end
  endtask

  initial begin
    int lows, own, sl, quiet;

    // req sid done ctl wd val lst srd srdy | grant sctl swd sval slst mrd mrdy busy
    tbl[0]  = '{2'b00,4'b0000,2'b00,2'b11,2'b11,2'b11,2'b11,3'b111,3'b111,
                2'b00,3'b000,3'b000,3'b000,3'b000,2'b00,2'b00,1'b0};
    tbl[1]  = '{2'b01,4'b0010,2'b00,2'b01,2'b00,2'b00,2'b00,3'b111,3'b111,
                2'b00,3'b000,3'b000,3'b000,3'b000,2'b00,2'b00,1'b0};
    tbl[2]  = '{2'b01,4'b0010,2'b00,2'b01,2'b01,2'b01,2'b01,3'b111,3'b111,
                2'b01,3'b000,3'b000,3'b000,3'b000,2'b00,2'b00,1'b1};
    tbl[3]  = '{2'b01,4'b0000,2'b00,2'b01,2'b01,2'b00,2'b00,3'b100,3'b100,
                2'b01,3'b100,3'b100,3'b000,3'b000,2'b01,2'b01,1'b1};
    tbl[4]  = '{2'b11,4'b0000,2'b00,2'b10,2'b00,2'b01,2'b01,3'b000,3'b011,
                2'b01,3'b000,3'b000,3'b100,3'b100,2'b00,2'b00,1'b1};
    tbl[5]  = '{2'b11,4'b0100,2'b01,2'b01,2'b10,2'b00,2'b00,3'b100,3'b100,
                2'b01,3'b100,3'b000,3'b000,3'b000,2'b01,2'b01,1'b1};
    tbl[6]  = '{2'b11,4'b0100,2'b00,2'b01,2'b01,2'b01,2'b01,3'b111,3'b111,
                2'b00,3'b000,3'b000,3'b000,3'b000,2'b00,2'b00,1'b0};
    tbl[7]  = '{2'b11,4'b0100,2'b00,2'b11,2'b11,2'b11,2'b11,3'b111,3'b111,
                2'b00,3'b000,3'b000,3'b000,3'b000,2'b00,2'b00,1'b0};
    tbl[8]  = '{2'b11,4'b0100,2'b00,2'b10,2'b10,2'b10,2'b10,3'b111,3'b111,
                2'b10,3'b000,3'b000,3'b000,3'b000,2'b00,2'b00,1'b1};
    tbl[9]  = '{2'b11,4'b0100,2'b00,2'b10,2'b10,2'b10,2'b00,3'b010,3'b010,
                2'b10,3'b010,3'b010,3'b010,3'b000,2'b10,2'b10,1'b1};
    tbl[10] = '{2'b01,4'b0100,2'b00,2'b00,2'b10,2'b00,2'b10,3'b000,3'b010,
                2'b10,3'b000,3'b010,3'b000,3'b010,2'b00,2'b10,1'b1};
    tbl[11] = '{2'b01,4'b0011,2'b00,2'b01,2'b01,2'b01,2'b01,3'b111,3'b111,
                2'b00,3'b000,3'b000,3'b000,3'b000,2'b00,2'b00,1'b0};
    tbl[12] = '{2'b01,4'b0011,2'b00,2'b01,2'b01,2'b01,2'b01,3'b111,3'b111,
                2'b00,3'b000,3'b000,3'b000,3'b000,2'b00,2'b00,1'b0};
    tbl[13] = '{2'b01,4'b0011,2'b00,2'b01,2'b01,2'b01,2'b01,3'b111,3'b111,
                2'b01,3'b000,3'b000,3'b000,3'b000,2'b00,2'b00,1'b1};
    tbl[14] = '{2'b01,4'b0011,2'b00,2'b01,2'b01,2'b01,2'b01,3'b111,3'b111,
                2'b01,3'b000,3'b000,3'b000,3'b000,2'b00,2'b00,1'b1};
    tbl[15] = '{2'b00,4'b0011,2'b00,2'b01,2'b01,2'b01,2'b01,3'b111,3'b111,
                2'b01,3'b000,3'b000,3'b000,3'b000,2'b00,2'b00,1'b1};
    tbl[16] = '{2'b00,4'b0011,2'b00,2'b01,2'b01,2'b01,2'b01,3'b111,3'b111,
                2'b00,3'b000,3'b000,3'b000,3'b000,2'b00,2'b00,1'b0};
    tbl[17] = '{2'b00,4'b0000,2'b00,2'b00,2'b00,2'b00,2'b00,3'b000,3'b000,
                2'b00,3'b000,3'b000,3'b000,3'b000,2'b00,2'b00,1'b0};

    do_reset();

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      m_req = tbl[i].req; m_slave_id = tbl[i].sid; m_done = tbl[i].done;
      m_control = tbl[i].ctl; m_wD = tbl[i].wd; m_valid = tbl[i].val; m_last = tbl[i].lst;
      s_rD = tbl[i].srd; s_ready = tbl[i].srdy;
      #1;
      chk($sformatf("v%0d_grant", i), 32'(m_grant), 32'(tbl[i].grant));
      chk($sformatf("v%0d_s_control", i), 32'(s_control), 32'(tbl[i].sctl));
      chk($sformatf("v%0d_s_wD", i), 32'(s_wD), 32'(tbl[i].swd));
      chk($sformatf("v%0d_s_valid", i), 32'(s_valid), 32'(tbl[i].sval));
      chk($sformatf("v%0d_s_last", i), 32'(s_last), 32'(tbl[i].slst));
      chk($sformatf("v%0d_m_rD", i), 32'(m_rD), 32'(tbl[i].mrd));
      chk($sformatf("v%0d_m_ready", i), 32'(m_ready), 32'(tbl[i].mrdy));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("v%0d_timeout", i), 32'(timeout), 32'(0));
    end

    // Both masters contend; each transaction ends with m_done after 10 BUSY cycles.
    do_reset();
    m_slave_id = 4'b1001;
    m_req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      own = (t == 1) ? 1 : 0;
      sl  = (own == 1) ? 2 : 1;
      wait_grant(lows);
      chk($sformatf("rr%0d_grant", t), 32'(m_grant), 32'(1 << own));
      if (t > 0) chk($sformatf("rr%0d_gap", t), 32'(lows), 32'(2));
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        m_control = 2'(k + t);
        if (k == 9) m_done = 2'(1 << own);
        #1;
        chk($sformatf("rr%0d_route%0d", t, k), 32'(s_control), 32'(m_control[own]) << sl);
      end
    end

    // Pointer now favours master 1; reset mid-BUSY must clear outputs and the pointer.
    wait_grant(lows);
    chk("pre_rst_grant", 32'(m_grant), 32'(2'b10));
    @(negedge clk);
    m_control = 2'b10; s_ready = 3'b111; s_rD = 3'b111;
    #1;
    chk("pre_rst_route", 32'(s_control), 32'(3'b100));
    chk("pre_rst_ready", 32'(m_ready), 32'(2'b10));
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_grant", 32'(m_grant), 32'(0));
    chk("async_rst_route", 32'(s_control), 32'(0));
    chk("async_rst_ready", 32'(m_ready), 32'(0));
    chk("async_rst_rD", 32'(m_rD), 32'(0));
    chk("async_rst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    resetn = 1'b1;
    wait_grant(lows);
    chk("post_rst_grant", 32'(m_grant), 32'(2'b01));
    chk("post_rst_busy", 32'(busy), 32'(1));
    m_req = '0;
    repeat (4) @(negedge clk);

`ifdef ARB_TIMEOUT_EN
    // Silent owner is forced off after TIMEOUT idle BUSY cycles.
    do_reset();
    m_req = 2'b11;
    wait_grant(lows);
    chk("tmo_first_grant", 32'(m_grant), 32'(2'b01));
    quiet = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #1;
      if (timeout) break;
      if (m_grant == 2'b01) quiet++;
    end
    chk("tmo_pulse", 32'(timeout), 32'(1));
    chk("tmo_release_grant", 32'(m_grant), 32'(0));
    chk("tmo_idle_cycles", 32'(quiet), 32'(8));
    @(negedge clk);
    #1;
    chk("tmo_one_cycle", 32'(timeout), 32'(0));
    wait_grant(lows);
    chk("tmo_next_grant", 32'(m_grant), 32'(2'b10));
    m_req = '0;
    repeat (4) @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
